// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Optional watchdog build switch: WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // replicated across the data bus on a watchdog-forced ack
  localparam logic TIMEOUT_DATA = 1'b1;

  function automatic logic [1:0] grant_of(state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    unique case (1'b1)
      (s == ST_OWN0): g = GNT_M0;
      (s == ST_OWN1): g = GNT_M1;
      default:        g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: fires for one cycle after TIMEOUT_CYCLES unacked strobes.
// Instantiated only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic strobe,
  input  logic ack,
  output logic fire
);

  logic [15:0] count;

  // the firing cycle is itself the last stalled cycle
  assign fire = ~idle & strobe & ~ack &
                (count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (idle || ack || fire) begin
      count <= '0;
    end else if (strobe) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin two-master Wishbone arbiter; grant held for a whole cycle.
// Optional stall watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbm0_address,
  input  logic [DATA_WIDTH-1:0] wbm0_writedata,
  output logic [DATA_WIDTH-1:0] wbm0_readdata,
  input  logic                  wbm0_write,
  input  logic                  wbm0_strobe,
  input  logic                  wbm0_cycle,
  output logic                  wbm0_ack,
  input  logic [ADDR_WIDTH-1:0] wbm1_address,
  input  logic [DATA_WIDTH-1:0] wbm1_writedata,
  output logic [DATA_WIDTH-1:0] wbm1_readdata,
  input  logic                  wbm1_write,
  input  logic                  wbm1_strobe,
  input  logic                  wbm1_cycle,
  output logic                  wbm1_ack,
  output logic [ADDR_WIDTH-1:0] wbs_address,
  output logic [DATA_WIDTH-1:0] wbs_writedata,
  input  logic [DATA_WIDTH-1:0] wbs_readdata,
  output logic                  wbs_write,
  output logic                  wbs_strobe,
  output logic                  wbs_cycle,
  input  logic                  wbs_ack,
  output logic [1:0]            grant
);

  state_t state, state_next;
  logic   last_owner, last_next;
  logic   own_strobe;
  logic   fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      last_owner <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last_owner;
    case (state)
      ST_IDLE: begin
        if (wbm0_cycle && wbm1_cycle) begin
          state_next = last_owner ? ST_OWN0 : ST_OWN1;
        end else if (wbm0_cycle) begin
          state_next = ST_OWN0;
        end else if (wbm1_cycle) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!wbm0_cycle) begin
          state_next = ST_IDLE;
          last_next  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!wbm1_cycle) begin
          state_next = ST_IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign grant = grant_of(state);

  always_comb begin
    own_strobe = 1'b0;
    case (state)
      ST_OWN0: own_strobe = wbm0_strobe;
      ST_OWN1: own_strobe = wbm1_strobe;
      default: own_strobe = 1'b0;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .idle  (state == ST_IDLE),
    .strobe(own_strobe),
    .ack   (wbs_ack),
    .fire  (fire)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign fire = 1'b0;
`endif

  always_comb begin
    wbs_address   = '0;
    wbs_writedata = '0;
    wbs_write     = 1'b0;
    wbs_strobe    = 1'b0;
    wbs_cycle     = 1'b0;
    wbm0_ack      = 1'b0;
    wbm1_ack      = 1'b0;
    wbm0_readdata = '0;
    wbm1_readdata = '0;
    case (state)
      ST_OWN0: begin
        wbs_address   = wbm0_address;
        wbs_writedata = wbm0_writedata;
        wbs_write     = wbm0_write;
        wbs_strobe    = own_strobe & ~fire;
        wbs_cycle     = wbm0_cycle;
        wbm0_ack      = wbs_ack | fire;
        wbm0_readdata = fire ? {DATA_WIDTH{TIMEOUT_DATA}}
                             : wbs_readdata;
      end
      ST_OWN1: begin
        wbs_address   = wbm1_address;
        wbs_writedata = wbm1_writedata;
        wbs_write     = wbm1_write;
        wbs_strobe    = own_strobe & ~fire;
        wbs_cycle     = wbm1_cycle;
        wbm1_ack      = wbs_ack | fire;
        wbm1_readdata = fire ? {DATA_WIDTH{TIMEOUT_DATA}}
                             : wbs_readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed table, corner
// sequences and random traffic against a reference model.
module tb_wb_arbiter_2m;

  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, reset;
  logic [7:0]  m0_a, m1_a, s_a;
  logic [15:0] m0_d, m1_d, m0_rd, m1_rd, s_d, s_rd;
  logic        m0_w, m0_s, m0_c, m0_k;
  logic        m1_w, m1_s, m1_c, m1_k;
  logic        s_w, s_s, s_c, s_k;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  // reference model: owner 0 = none, 1 = m0, 2 = m1
  int m_owner, m_last, m_stall;

  wb_arbiter_2m #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .wbm0_address(m0_a), .wbm0_writedata(m0_d),
    .wbm0_readdata(m0_rd), .wbm0_write(m0_w),
    .wbm0_strobe(m0_s), .wbm0_cycle(m0_c), .wbm0_ack(m0_k),
    .wbm1_address(m1_a), .wbm1_writedata(m1_d),
    .wbm1_readdata(m1_rd), .wbm1_write(m1_w),
    .wbm1_strobe(m1_s), .wbm1_cycle(m1_c), .wbm1_ack(m1_k),
    .wbs_address(s_a), .wbs_writedata(s_d),
    .wbs_readdata(s_rd), .wbs_write(s_w),
    .wbs_strobe(s_s), .wbs_cycle(s_c), .wbs_ack(s_k),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_fire();
    bit stb;
    stb = (m_owner == 1) ? m0_s : (m_owner == 2) ? m1_s : 1'b0;
    return TO_EN && m_owner != 0 && stb && !s_k &&
           m_stall == TO - 1;
  endfunction

  task automatic check_all();
    bit f;
    logic [7:0] ea;
    logic [15:0] ed, er0, er1;
    logic ew, es, ec, ek0, ek1;
    logic [1:0] eg;
    f = m_fire();
    ea = 0; ed = 0; ew = 0; es = 0; ec = 0;
    ek0 = 0; ek1 = 0; er0 = 0; er1 = 0; eg = 0;
    if (m_owner == 1) begin
      ea = m0_a; ed = m0_d; ew = m0_w; es = m0_s && !f; ec = m0_c;
      ek0 = s_k || f; er0 = f ? 16'hFFFF : s_rd; eg = 2'b01;
    end else if (m_owner == 2) begin
      ea = m1_a; ed = m1_d; ew = m1_w; es = m1_s && !f; ec = m1_c;
      ek1 = s_k || f; er1 = f ? 16'hFFFF : s_rd; eg = 2'b10;
    end
    chk("wbs_address", 32'(s_a), 32'(ea));
    chk("wbs_writedata", 32'(s_d), 32'(ed));
    chk("wbs_write", 32'(s_w), 32'(ew));
    chk("wbs_strobe", 32'(s_s), 32'(es));
    chk("wbs_cycle", 32'(s_c), 32'(ec));
    chk("grant", 32'(grant), 32'(eg));
    chk("wbm0_ack", 32'(m0_k), 32'(ek0));
    chk("wbm1_ack", 32'(m1_k), 32'(ek1));
    chk("wbm0_readdata", 32'(m0_rd), 32'(er0));
    chk("wbm1_readdata", 32'(m1_rd), 32'(er1));
  endtask

  task automatic model_edge();
    bit f, stb;
    f = m_fire();
    stb = (m_owner == 1) ? m0_s : (m_owner == 2) ? m1_s : 1'b0;
    if (m_owner == 0 || s_k || f) m_stall = 0;
    else if (stb) m_stall++;
    if (m_owner == 0) begin
      if (m0_c && m1_c) m_owner = (m_last == 1) ? 2 : 1;
      else if (m0_c) m_owner = 1;
      else if (m1_c) m_owner = 2;
    end else if ((m_owner == 1 && !m0_c) || (m_owner == 2 && !m1_c)) begin
      m_last = m_owner;
      m_owner = 0;
      m_stall = 0;
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_stall = 0;
  endtask

  // sample at negedge, advance model at posedge, drive again at +1
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    bit rs, c0, w0, c1, w1, sack;
    logic [15:0] srd;
    logic [1:0]  eg;
    bit ea0, ea1;
    logic [15:0] erd1;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rs, bit c0, bit w0, bit c1, bit w1,
                              bit sack, logic [15:0] srd, logic [1:0] eg,
                              bit ea0, bit ea1, logic [15:0] erd1);
    vec_t v;
    v.rs = rs; v.c0 = c0; v.w0 = w0; v.c1 = c1; v.w1 = w1;
    v.sack = sack; v.srd = srd; v.eg = eg;
    v.ea0 = ea0; v.ea1 = ea1; v.erd1 = erd1;
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    m0_a = 0; m0_d = 0; m0_w = 0; m0_s = 0; m0_c = 0;
    m1_a = 0; m1_d = 0; m1_w = 0; m1_s = 0; m1_c = 0;
    s_rd = 0; s_k = 0;
    model_reset();

    // reset state while reset is held, with a stray ack
    s_k = 1'b1;
    @(negedge clk);
    check_all();
    s_k = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // single m0 write
    tv.push_back(mk(1,1,1,0,0,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,1,1,0,0,1,0,2'b01,1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,2'b01,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,2'b00,0,0,0));
    // tie after reset: m0 first, then m1 after one idle cycle
    tv.push_back(mk(1,1,1,1,1,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,1,1,1,1,1,0,2'b01,1,0,0));
    tv.push_back(mk(0,0,1,1,1,0,0,2'b01,0,0,0));
    tv.push_back(mk(0,0,0,1,1,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,0,0,1,1,1,0,2'b10,0,1,0));
    tv.push_back(mk(0,0,0,0,1,0,0,2'b10,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0,0,2'b00,0,0,0));
    // continuous requests alternate
    tv.push_back(mk(0,1,1,1,1,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,1,1,1,1,1,0,2'b01,1,0,0));
    tv.push_back(mk(0,0,1,1,1,0,0,2'b01,0,0,0));
    tv.push_back(mk(0,1,1,1,1,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,1,1,1,1,1,0,2'b10,0,1,0));
    tv.push_back(mk(0,1,1,0,1,0,0,2'b10,0,0,0));
    tv.push_back(mk(0,1,1,1,1,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,1,1,1,1,0,0,2'b01,0,0,0));
    // m1 read returning 0x1234
    tv.push_back(mk(1,0,0,1,0,0,0,2'b00,0,0,0));
    tv.push_back(mk(0,0,0,1,0,1,16'h1234,2'b10,0,1,16'h1234));
    tv.push_back(mk(0,0,0,0,0,0,0,2'b10,0,0,0));
    // m0 burst of three while m1 waits; ack in idle dropped
    tv.push_back(mk(1,1,1,1,1,0,0,2'b00,0,0,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0,1,1,1,1,1,0,2'b01,1,0,0));
    tv.push_back(mk(0,0,1,1,1,0,0,2'b01,0,0,0));
    tv.push_back(mk(0,0,0,1,1,1,0,2'b00,0,0,0));
    tv.push_back(mk(0,0,0,1,1,1,0,2'b10,0,1,0));

    foreach (tv[i]) begin
      if (tv[i].rs) do_reset();
      m0_a = 8'h00; m0_d = 16'h00A5;
      m0_c = tv[i].c0; m0_s = tv[i].c0; m0_w = tv[i].w0;
      m1_a = 8'h40; m1_d = 16'h0003;
      m1_c = tv[i].c1; m1_s = tv[i].c1; m1_w = tv[i].w1;
      s_k = tv[i].sack; s_rd = tv[i].srd;
      @(negedge clk);
      chk($sformatf("tv%0d grant", i), 32'(grant), 32'(tv[i].eg));
      chk($sformatf("tv%0d ack0", i), 32'(m0_k), 32'(tv[i].ea0));
      chk($sformatf("tv%0d ack1", i), 32'(m1_k), 32'(tv[i].ea1));
      chk($sformatf("tv%0d rd1", i), 32'(m1_rd), 32'(tv[i].erd1));
      check_all();
      @(posedge clk);
      model_edge();
      #1;
    end

    // stalled slave: m0 strobes and never sees a real ack
    do_reset();
    m0_c = 1; m0_s = 1; m0_w = 0; m1_c = 0; m1_s = 0;
    s_k = 0; s_rd = 16'h5A5A;
    cycle();
    for (int k = 1; k <= (TO_EN ? 20 : 100); k++) begin
      bit e;
      e = TO_EN && (k % TO == 0);
      @(negedge clk);
      chk($sformatf("stall%0d ack0", k), 32'(m0_k), 32'(e));
      chk($sformatf("stall%0d strobe", k), 32'(s_s), 32'(!e));
      chk($sformatf("stall%0d grant", k), 32'(grant), 32'h1);
      if (e) chk("stall rd0", 32'(m0_rd), 32'hFFFF);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
    end

    // reset mid-transfer drops cycle without a clock edge
    reset = 1'b0;
    #1;
    chk("async wbs_cycle", 32'(s_c), 32'h0);
    chk("async grant", 32'(grant), 32'h0);
    model_reset();
    #1;
    reset = 1'b1;
    m0_c = 0; m0_s = 0;
    cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (m0_c) m0_c = ($urandom_range(5) != 0);
      else      m0_c = ($urandom_range(2) == 0);
      if (m1_c) m1_c = ($urandom_range(5) != 0);
      else      m1_c = ($urandom_range(2) == 0);
      m0_s = m0_c && ($urandom_range(3) != 0);
      m1_s = m1_c && ($urandom_range(3) != 0);
      m0_w = 1'($urandom); m1_w = 1'($urandom);
      m0_a = 8'($urandom); m1_a = 8'($urandom);
      m0_d = 16'($urandom); m1_d = 16'($urandom);
      s_k = ($urandom_range(3) == 0);
      s_rd = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
